single_cycle_datapath: RTL and testbench

//  Single-cycle MIPS-subset datapath: add, sub, and, or, slt, lw, sw, beq.

---
 rtl/dp_pkg.sv | 52 +++++
 rtl/dp_regfile.sv | 43 ++++
 rtl/single_cycle_datapath.sv | 160 ++++++++++++++++
 tb/tb_single_cycle_datapath.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the single-cycle MIPS-subset datapath:
// opcodes, ALU operations, reset presets and the constant program image.
package dp_pkg;

    localparam logic [31:0] TEXT_BASE_DFLT  = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE_DFLT  = 32'h1001_0000;
    localparam int          IMEM_WORDS_DFLT = 64;
    localparam int          DMEM_WORDS_DFLT = 64;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    localparam logic [31:0] RST_R1    = 32'd1;
    localparam logic [31:0] RST_R2    = 32'd2;
    localparam logic [31:0] RST_DMEM0 = 32'd100;
    localparam logic [31:0] RST_DMEM1 = 32'd200;

    // Program image; words past the listed ones read as zero (a no-op).
    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        case (idx)
            32'd0:   rom_word = 32'h0022_1820;
            32'd1:   rom_word = 32'h0022_1822;
            32'd2:   rom_word = 32'h0022_1824;
            32'd3:   rom_word = 32'h0022_1825;
            32'd4:   rom_word = 32'h0022_182A;
            32'd5:   rom_word = 32'h0041_182A;
            32'd6:   rom_word = 32'h1140_FFF9;
            32'd7:   rom_word = 32'h8D43_0000;
            32'd8:   rom_word = 32'h8D43_0004;
            32'd9:   rom_word = 32'hAD43_0008;
            32'd10:  rom_word = 32'h1000_FFF5;
            default: rom_word = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/dp_regfile.sv
// 32x32 register file: two combinational read ports, one write port,
// asynchronous reset to the preset values, $0 hardwired to zero.
module dp_regfile
    import dp_pkg::*;
#(
    parameter logic [31:0] DATA_BASE = DATA_BASE_DFLT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [4:0]  i_rs_addr,
    input  logic [4:0]  i_rt_addr,
    output logic [31:0] o_rs_data,
    output logic [31:0] o_rt_data,
    input  logic        i_we,
    input  logic [4:0]  i_wr_addr,
    input  logic [31:0] i_wr_data
);

    logic [31:0] regs [32];

    function automatic logic [31:0] preset(input int n);
        case (n)
            1:       preset = RST_R1;
            2:       preset = RST_R2;
            10:      preset = DATA_BASE;
            default: preset = 32'h0;
        endcase
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= preset(i);
            end
        end else if (i_we && (i_wr_addr != 5'd0)) begin
            regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rs_data = (i_rs_addr == 5'd0) ? 32'h0 : regs[i_rs_addr];
    assign o_rt_data = (i_rt_addr == 5'd0) ? 32'h0 : regs[i_rt_addr];

endmodule

// File: rtl/single_cycle_datapath.sv
// Single-cycle MIPS-subset core (add/sub/and/or/slt/lw/sw/beq) with its own
// instruction ROM, register file and data RAM; every instruction retires in one clock.
module single_cycle_datapath
    import dp_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE  = TEXT_BASE_DFLT,
    parameter logic [31:0] DATA_BASE  = DATA_BASE_DFLT,
    parameter int          IMEM_WORDS = IMEM_WORDS_DFLT,
    parameter int          DMEM_WORDS = DMEM_WORDS_DFLT
) (
    input  logic clock,
    input  logic clear
);

    localparam int DIDX_W = $clog2(DMEM_WORDS);

    logic [31:0] pc;
    logic [31:0] dmem [DMEM_WORDS];

    logic [31:0] w_imem_off;
    logic        w_imem_hit;
    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_sext;

    logic        w_reg_write;
    logic        w_mem_write;
    logic        w_reg_dst_rd;
    logic        w_alu_src_imm;
    logic        w_wb_from_mem;
    logic        w_is_beq;
    alu_op_t     w_alu_op;

    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;
    logic [31:0] w_dmem_off;
    logic        w_dmem_hit;
    logic [DIDX_W-1:0] w_dmem_idx;
    logic [31:0] w_dmem_rdata;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic        w_branch_taken;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_unused_bits;

    assign w_imem_off = pc - TEXT_BASE;
    assign w_imem_hit = w_imem_off[31:2] < 30'(IMEM_WORDS);
    assign w_instr    = w_imem_hit ? rom_word({2'b00, w_imem_off[31:2]}) : 32'h0;

    assign w_op    = w_instr[31:26];
    assign w_rs    = w_instr[25:21];
    assign w_rt    = w_instr[20:16];
    assign w_rd    = w_instr[15:11];
    assign w_funct = w_instr[5:0];
    assign w_sext  = {{16{w_instr[15]}}, w_instr[15:0]};

    // Unrecognised encodings fall through with all enables low: a plain pc+4.
    always_comb begin
        w_reg_write   = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_dst_rd  = 1'b0;
        w_alu_src_imm = 1'b0;
        w_wb_from_mem = 1'b0;
        w_is_beq      = 1'b0;
        w_alu_op      = ALU_ADD;
        case (w_op)
            OP_RTYPE: begin
                w_reg_dst_rd = 1'b1;
                w_reg_write  = 1'b1;
                case (w_funct)
                    FN_ADD:  w_alu_op = ALU_ADD;
                    FN_SUB:  w_alu_op = ALU_SUB;
                    FN_AND:  w_alu_op = ALU_AND;
                    FN_OR:   w_alu_op = ALU_OR;
                    FN_SLT:  w_alu_op = ALU_SLT;
                    default: w_reg_write = 1'b0;
                endcase
            end
            OP_LW: begin
                w_alu_src_imm = 1'b1;
                w_wb_from_mem = 1'b1;
                w_reg_write   = 1'b1;
            end
            OP_SW: begin
                w_alu_src_imm = 1'b1;
                w_mem_write   = 1'b1;
            end
            OP_BEQ:  w_is_beq = 1'b1;
            default: ;
        endcase
    end

    dp_regfile #(
        .DATA_BASE (DATA_BASE)
    ) u_regfile (
        .i_clk     (clock),
        .i_rst_n   (clear),
        .i_rs_addr (w_rs),
        .i_rt_addr (w_rt),
        .o_rs_data (w_rs_data),
        .o_rt_data (w_rt_data),
        .i_we      (w_reg_write),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data)
    );

    assign w_alu_b = w_alu_src_imm ? w_sext : w_rt_data;

    always_comb begin
        w_alu_result = 32'h0;
        case (w_alu_op)
            ALU_ADD: w_alu_result = w_rs_data + w_alu_b;
            ALU_SUB: w_alu_result = w_rs_data - w_alu_b;
            ALU_AND: w_alu_result = w_rs_data & w_alu_b;
            ALU_OR:  w_alu_result = w_rs_data | w_alu_b;
            ALU_SLT: w_alu_result = {31'h0, $signed(w_rs_data) < $signed(w_alu_b)};
            default: w_alu_result = 32'h0;
        endcase
    end

    assign w_dmem_off   = w_alu_result - DATA_BASE;
    assign w_dmem_hit   = w_dmem_off[31:2] < 30'(DMEM_WORDS);
    assign w_dmem_idx   = w_dmem_off[DIDX_W+1:2];
    assign w_dmem_rdata = w_dmem_hit ? dmem[w_dmem_idx] : 32'h0;

    assign w_wr_addr = w_reg_dst_rd ? w_rd : w_rt;
    assign w_wr_data = w_wb_from_mem ? w_dmem_rdata : w_alu_result;

    assign w_branch_taken = w_is_beq && (w_rs_data == w_rt_data);
    assign w_pc_plus4     = pc + 32'd4;
    assign w_pc_next      = w_branch_taken ? (w_pc_plus4 + {w_sext[29:0], 2'b00}) : w_pc_plus4;

    assign w_unused_bits = &{1'b0, w_imem_off[1:0], w_dmem_off[1:0], w_instr[10:6]};

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pc <= TEXT_BASE;
        end else begin
            pc <= w_pc_next;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                dmem[i] <= (i == 0) ? RST_DMEM0 : ((i == 1) ? RST_DMEM1 : 32'h0);
            end
        end else if (w_mem_write && w_dmem_hit) begin
            dmem[w_dmem_idx] <= w_rt_data;
        end
    end

endmodule

// File: tb/tb_single_cycle_datapath.sv
// Bench for single_cycle_datapath: directed program walk plus randomized run
// lengths and asynchronous reset points, checked against an instruction-level model.
module tb_single_cycle_datapath;

    localparam logic [31:0] TB_TEXT = 32'h0040_0000;
    localparam logic [31:0] TB_DATA = 32'h1001_0000;

    logic clock;
    logic clear;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [64];

    single_cycle_datapath dut (
        .clock (clock),
        .clear (clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] tb_rom(input logic [31:0] idx);
        logic [31:0] img [11];
        img = '{32'h00221820, 32'h00221822, 32'h00221824, 32'h00221825,
                32'h0022182A, 32'h0041182A, 32'h1140FFF9, 32'h8D430000,
                32'h8D430004, 32'hAD430008, 32'h1000FFF5};
        return (idx < 32'd11) ? img[idx] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = TB_TEXT;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_regs[1]  = 32'd1;
        m_regs[2]  = 32'd2;
        m_regs[10] = TB_DATA;
        for (int i = 0; i < 64; i++) m_dmem[i] = 32'h0;
        m_dmem[0] = 32'd100;
        m_dmem[1] = 32'd200;
    endtask

    // One instruction executed directly from the ISA definition.
    task automatic model_step();
        logic [31:0] w, a, b, sext, addr, di, res, npc;
        int op, fn, rs, rt, rd;
        bit wr;
        w    = tb_rom((m_pc - TB_TEXT) / 4);
        op   = int'(w[31:26]);
        rs   = int'(w[25:21]);
        rt   = int'(w[20:16]);
        rd   = int'(w[15:11]);
        fn   = int'(w[5:0]);
        sext = {{16{w[15]}}, w[15:0]};
        a    = m_regs[rs];
        b    = m_regs[rt];
        addr = a + sext;
        di   = (addr - TB_DATA) / 4;
        npc  = m_pc + 4;
        if (op == 0) begin
            wr  = 1'b1;
            res = 32'h0;
            case (fn)
                'h20: res = a + b;
                'h22: res = a - b;
                'h24: res = a & b;
                'h25: res = a | b;
                'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: wr = 1'b0;
            endcase
            if (wr && rd != 0) m_regs[rd] = res;
        end else if (op == 'h23) begin
            if (rt != 0) m_regs[rt] = (di < 64) ? m_dmem[di] : 32'h0;
        end else if (op == 'h2B) begin
            if (di < 64) m_dmem[di] = b;
        end else if (op == 'h04) begin
            if (a == b) npc = m_pc + 4 + (sext * 4);
        end
        m_pc = npc;
    endtask

    task automatic compare_all();
        check("pc", dut.pc, m_pc);
        for (int i = 0; i < 32; i++) check($sformatf("reg%0d", i), dut.u_regfile.regs[i], m_regs[i]);
        for (int i = 0; i < 64; i++) check($sformatf("dmem%0d", i), dut.dmem[i], m_dmem[i]);
    endtask

    task automatic edge_and_check();
        @(posedge clock);
        #1;
        model_step();
        compare_all();
    endtask

    initial begin
        logic [31:0] exp_r3 [6];
        int run_len;
        int hold;
        exp_r3 = '{32'd3, 32'hFFFF_FFFF, 32'd0, 32'd3, 32'd1, 32'd0};

        clear = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        model_reset();
        check("rst_pc", dut.pc, 32'h0040_0000);
        check("rst_r1", dut.u_regfile.regs[1], 32'd1);
        check("rst_r2", dut.u_regfile.regs[2], 32'd2);
        check("rst_r10", dut.u_regfile.regs[10], 32'h1001_0000);
        check("rst_dmem0", dut.dmem[0], 32'd100);
        check("rst_dmem1", dut.dmem[1], 32'd200);
        compare_all();

        @(negedge clock);
        clear = 1'b1;
        for (int e = 0; e < 6; e++) begin
            edge_and_check();
            check($sformatf("seq_r3_e%0d", e + 1), dut.u_regfile.regs[3], exp_r3[e]);
        end
        check("pc_after6", dut.pc, 32'h0040_0018);
        edge_and_check();
        check("beq_not_taken_pc", dut.pc, 32'h0040_001C);
        check("beq_not_taken_r3", dut.u_regfile.regs[3], 32'd0);
        edge_and_check();
        check("lw0_r3", dut.u_regfile.regs[3], 32'd100);
        edge_and_check();
        check("lw4_r3", dut.u_regfile.regs[3], 32'd200);
        edge_and_check();
        check("sw_dmem2", dut.dmem[2], 32'd200);
        edge_and_check();
        check("beq_taken_pc", dut.pc, 32'h0040_0000);
        edge_and_check();
        check("wrap_r3", dut.u_regfile.regs[3], 32'd3);

        // Restart, run to just after the store, then reset mid-cycle.
        @(negedge clock);
        clear = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clock);
        clear = 1'b1;
        repeat (10) edge_and_check();
        check("pre_rst_dmem2", dut.dmem[2], 32'd200);
        #2;
        clear = 1'b0;
        #1;
        check("async_pc", dut.pc, 32'h0040_0000);
        check("async_r3", dut.u_regfile.regs[3], 32'd0);
        check("async_dmem2", dut.dmem[2], 32'd0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare_all();
        @(negedge clock);
        clear = 1'b1;
        for (int e = 0; e < 12; e++) edge_and_check();
        check("restart_r3", dut.u_regfile.regs[3], 32'd3);

        for (int it = 0; it < 25; it++) begin
            run_len = int'($urandom_range(1, 30));
            for (int e = 0; e < run_len; e++) edge_and_check();
            #($urandom_range(1, 3));
            clear = 1'b0;
            #1;
            model_reset();
            compare_all();
            hold = int'($urandom_range(0, 3));
            repeat (hold) @(posedge clock);
            #1;
            compare_all();
            @(negedge clock);
            clear = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
